// File: rtl/sram_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
// Shared definitions for the SRAM burst core: default geometry constants and
// the access-sequencer state encoding.
// -----------------------------------------------------------------------------
package sram_pkg;

   // Default geometry: 64 rows x 16 words x 4 bits, bursts of up to 8 beats.
   localparam int SRAM_ROW_BITS  = 6;
   localparam int SRAM_COL_BITS  = 4;
   localparam int SRAM_WORD_SIZE = 4;
   localparam int SRAM_LEN_BITS  = 3;

   // Sequencer states: idle, row precharge, word access.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PRE  = 2'd1,
      ACC  = 2'd2
   } state_e;

endpackage

// File: rtl/sram_array_model.sv
// -----------------------------------------------------------------------------
// sram_array_model
// Behavioural stand-in for the SRAM macro. Storage is organised as rows of
// 2**COL_BITS words. Writes are per-bit masked and take effect on the rising
// clock edge; reads are combinational from the addressed word. Contents are not
// affected by reset; the model starts with every word at zero.
//
// Ports:
//   clk    - write clock
//   we     - write strobe for the addressed word
//   row    - row address
//   col    - column (word) address within the row
//   wdata  - write data
//   wmask  - per-bit write enable, 1 = bit is written
//   rdata  - addressed word (combinational)
// -----------------------------------------------------------------------------
module sram_array_model #(
   parameter int ROW_BITS  = 6,
   parameter int COL_BITS  = 4,
   parameter int WORD_SIZE = 4
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [ROW_BITS-1:0]  row,
   input  logic [COL_BITS-1:0]  col,
   input  logic [WORD_SIZE-1:0] wdata,
   input  logic [WORD_SIZE-1:0] wmask,
   output logic [WORD_SIZE-1:0] rdata
);

   localparam int NUM_ROWS = 2 ** ROW_BITS;
   localparam int NUM_COLS = 2 ** COL_BITS;

   // One entry per row; each row packs NUM_COLS words side by side.
   logic [NUM_COLS-1:0][WORD_SIZE-1:0] mem_r [NUM_ROWS] = '{default: '0};

   // Masked word write: only bits with wmask=1 take the new value.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[row][col] <= (mem_r[row][col] & ~wmask) | (wdata & wmask);
      end
   end

   // Combinational word read of the addressed location.
   always_comb begin
      rdata = mem_r[row][col];
   end

endmodule

// File: rtl/sram_burst_core.sv
// -----------------------------------------------------------------------------
// sram_burst_core
// Burst sequencer in front of an SRAM array. A request (read or write, start
// address, beats-minus-one) is accepted in IDLE; each beat then spends one
// cycle in PRE (precharge) and at least one cycle in ACC (access). Reads take
// exactly one ACC cycle; writes stay in ACC until a write beat is offered.
// The column advances modulo the row width between beats, the row is fixed.
//
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   req_valid / req_ready    - request handshake (ready only in IDLE)
//   req_write                - 1 = write burst, 0 = read burst
//   req_addr                 - {row, column} start address
//   req_len                  - number of beats minus one
//   wdata, wmask             - write beat data and per-bit write enable
//   wdata_valid/wdata_ready  - write beat handshake (ready only in write ACC)
//   rdata, rdata_valid       - read beat data, one-cycle valid pulse
//   done                     - one-cycle pulse after the final beat
// -----------------------------------------------------------------------------
module sram_burst_core
   import sram_pkg::*;
#(
   parameter int ROW_BITS  = SRAM_ROW_BITS,
   parameter int COL_BITS  = SRAM_COL_BITS,
   parameter int WORD_SIZE = SRAM_WORD_SIZE,
   parameter int LEN_BITS  = SRAM_LEN_BITS
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic                         req_write,
   input  logic [ROW_BITS+COL_BITS-1:0] req_addr,
   input  logic [LEN_BITS-1:0]          req_len,
   input  logic [WORD_SIZE-1:0]         wdata,
   input  logic [WORD_SIZE-1:0]         wmask,
   input  logic                         wdata_valid,
   output logic                         wdata_ready,
   output logic [WORD_SIZE-1:0]         rdata,
   output logic                         rdata_valid,
   output logic                         done
);

   state_e                 state_r;
   logic                   wr_r;
   logic [ROW_BITS-1:0]    row_r;
   logic [COL_BITS-1:0]    col_r;
   logic [LEN_BITS-1:0]    remain_r;
   logic                   req_ready_r;
   logic                   wdata_ready_r;
   logic [WORD_SIZE-1:0]   rdata_r;
   logic                   rdata_valid_r;
   logic                   done_r;

   logic [WORD_SIZE-1:0]   array_rdata_s;
   logic                   array_we_s;
   logic                   beat_done_s;

   // Decode the end of an access beat and the array write strobe.
   // Reset is folded into the strobe so an aborted write never lands.
   always_comb begin
      beat_done_s = 1'b0;
      array_we_s  = 1'b0;
      if (state_r == ACC) begin
         if (wr_r) begin
            beat_done_s = wdata_valid;
            array_we_s  = wdata_valid & ~rst;
         end else begin
            beat_done_s = 1'b1;
            array_we_s  = 1'b0;
         end
      end else begin
         beat_done_s = 1'b0;
         array_we_s  = 1'b0;
      end
   end

   // Burst sequencer with registered handshake and read outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= IDLE;
         wr_r          <= 1'b0;
         row_r         <= '0;
         col_r         <= '0;
         remain_r      <= '0;
         req_ready_r   <= 1'b1;
         wdata_ready_r <= 1'b0;
         rdata_r       <= '0;
         rdata_valid_r <= 1'b0;
         done_r        <= 1'b0;
      end else begin
         // Pulses default low and are raised only on the cycle they apply.
         rdata_valid_r <= 1'b0;
         done_r        <= 1'b0;
         case (state_r)
            IDLE: begin
               if (req_valid && req_ready_r) begin
                  wr_r        <= req_write;
                  row_r       <= req_addr[ROW_BITS+COL_BITS-1:COL_BITS];
                  col_r       <= req_addr[COL_BITS-1:0];
                  remain_r    <= req_len;
                  req_ready_r <= 1'b0;
                  state_r     <= PRE;
               end
            end
            PRE: begin
               // Write beats are offered only while sitting in ACC.
               wdata_ready_r <= wr_r;
               state_r       <= ACC;
            end
            ACC: begin
               if (beat_done_s) begin
                  wdata_ready_r <= 1'b0;
                  if (!wr_r) begin
                     rdata_r       <= array_rdata_s;
                     rdata_valid_r <= 1'b1;
                  end
                  if (remain_r == '0) begin
                     req_ready_r <= 1'b1;
                     done_r      <= 1'b1;
                     state_r     <= IDLE;
                  end else begin
                     // Column wraps within the row; row stays fixed.
                     remain_r <= remain_r - LEN_BITS'(1);
                     col_r    <= col_r + COL_BITS'(1);
                     state_r  <= PRE;
                  end
               end
            end
            default: begin
               req_ready_r   <= 1'b1;
               wdata_ready_r <= 1'b0;
               state_r       <= IDLE;
            end
         endcase
      end
   end

   sram_array_model #(
      .ROW_BITS  (ROW_BITS),
      .COL_BITS  (COL_BITS),
      .WORD_SIZE (WORD_SIZE)
   ) u_array (
      .clk   (clk),
      .we    (array_we_s),
      .row   (row_r),
      .col   (col_r),
      .wdata (wdata),
      .wmask (wmask),
      .rdata (array_rdata_s)
   );

   assign req_ready   = req_ready_r;
   assign wdata_ready = wdata_ready_r;
   assign rdata       = rdata_r;
   assign rdata_valid = rdata_valid_r;
   assign done        = done_r;

endmodule

// File: tb/tb_sram_burst_core.sv
// -----------------------------------------------------------------------------
// tb_sram_burst_core
// Directed and randomized bursts against sram_burst_core. Expected read data
// comes from a flat word-addressed memory kept in the bench; expected timing
// comes from the beat rules (one precharge cycle, one access cycle per beat,
// write beats stalling until offered).
// -----------------------------------------------------------------------------
module tb_sram_burst_core;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   logic       req_write;
   logic [9:0] req_addr;
   logic [2:0] req_len;
   logic [3:0] wdata;
   logic [3:0] wmask;
   logic       wdata_valid;
   logic       wdata_ready;
   logic [3:0] rdata;
   logic       rdata_valid;
   logic       done;

   sram_burst_core dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_write   (req_write),
      .req_addr    (req_addr),
      .req_len     (req_len),
      .wdata       (wdata),
      .wmask       (wmask),
      .wdata_valid (wdata_valid),
      .wdata_ready (wdata_ready),
      .rdata       (rdata),
      .rdata_valid (rdata_valid),
      .done        (done)
   );

   always #5 clk = ~clk;

   int         vectors     = 0;
   int         miscompares = 0;
   logic [3:0] ref_mem [1024];
   logic [3:0] bdata [8];
   logic [3:0] bmask [8];
   int         stall_beat   = -1;
   int         stall_cycles = 0;
   bit         chain_pending = 1'b0;
   logic       chain_wr;
   logic [9:0] chain_addr;
   logic [2:0] chain_len;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Word address of beat b: row fixed, column wraps inside the row.
   function automatic logic [9:0] beat_addr(input logic [9:0] addr, input int b);
      return (addr & 10'h3F0) | ((addr + 10'(b)) & 10'h00F);
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic burst(input logic wr, input logic [9:0] addr, input int len, input bit no_gap);
      int         n;
      logic [9:0] a;
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_len   = 3'(len);
      n = 0;
      while (req_ready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      check("ready_before_accept", 32'(req_ready), 32'd1);
      if (no_gap) check("back_to_back_gap", 32'(n), 32'd0);
      tick();                               // acceptance edge
      req_valid = 1'b0;
      check("pre_ready_low", 32'(req_ready), 32'd0);
      check("pre_wready_low", 32'(wdata_ready), 32'd0);
      for (int b = 0; b <= len; b++) begin
         a = beat_addr(addr, b);
         tick();                            // now in the access cycle
         check("acc_wready", 32'(wdata_ready), 32'(wr));
         check("acc_rvalid_low", 32'(rdata_valid), 32'd0);
         if (wr) begin
            if (b == stall_beat) begin
               for (int s = 0; s < stall_cycles; s++) begin
                  tick();
                  check("stall_wready", 32'(wdata_ready), 32'd1);
                  check("stall_ready", 32'(req_ready), 32'd0);
                  check("stall_done", 32'(done), 32'd0);
               end
            end
            wdata_valid = 1'b1;
            wdata       = bdata[b];
            wmask       = bmask[b];
            ref_mem[a]  = (ref_mem[a] & ~bmask[b]) | (bdata[b] & bmask[b]);
         end
         if (b == len && chain_pending) begin
            req_valid     = 1'b1;
            req_write     = chain_wr;
            req_addr      = chain_addr;
            req_len       = chain_len;
            chain_pending = 1'b0;
         end
         tick();
         wdata_valid = 1'b0;
         check("beat_rvalid", 32'(rdata_valid), 32'(!wr));
         if (!wr) check("beat_rdata", 32'(rdata), 32'(ref_mem[a]));
         check("beat_done", 32'(done), 32'(b == len));
         check("beat_wready_low", 32'(wdata_ready), 32'd0);
         check("beat_ready", 32'(req_ready), 32'(b == len));
      end
   endtask

   task automatic accept(input logic wr, input logic [9:0] addr, input logic [2:0] len);
      int n;
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_len   = len;
      n = 0;
      while (req_ready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      check("accept_ready", 32'(req_ready), 32'd1);
      tick();
      req_valid = 1'b0;
   endtask

   task automatic fill_beats(input logic [3:0] d0, input logic [3:0] m);
      for (int i = 0; i < 8; i++) begin
         bdata[i] = d0 + 4'(i);
         bmask[i] = m;
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = 4'h0;
      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 10'h000;
      req_len = 3'd0; wdata = 4'h0; wmask = 4'h0; wdata_valid = 1'b0;
      repeat (3) tick();
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_wdata_ready", 32'(wdata_ready), 32'd0);
      check("rst_rdata", 32'(rdata), 32'd0);
      check("rst_rdata_valid", 32'(rdata_valid), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      rst = 1'b0;
      tick();

      // Single-beat write then read, fixed latency.
      bdata[0] = 4'hA; bmask[0] = 4'hF;
      burst(1'b1, 10'h025, 0, 1'b0);
      burst(1'b0, 10'h025, 0, 1'b0);
      check("single_read_value", 32'(rdata), 32'hA);

      // Burst wrapping columns E,F,0,1 of row 3; row 4 untouched.
      fill_beats(4'h1, 4'hF);
      burst(1'b1, 10'h03E, 3, 1'b0);
      burst(1'b0, 10'h03E, 3, 1'b0);
      burst(1'b0, 10'h040, 7, 1'b0);
      burst(1'b0, 10'h048, 7, 1'b0);

      // Partial mask keeps unmasked bits.
      bdata[0] = 4'hF; bmask[0] = 4'hF;
      burst(1'b1, 10'h100, 0, 1'b0);
      bdata[0] = 4'h0; bmask[0] = 4'h5;
      burst(1'b1, 10'h100, 0, 1'b0);
      burst(1'b0, 10'h100, 0, 1'b0);
      check("masked_value", 32'(rdata), 32'hA);

      // Write stall of five cycles in beat 2.
      fill_beats(4'h6, 4'hF);
      stall_beat = 1; stall_cycles = 5;
      burst(1'b1, 10'h2C8, 2, 1'b0);
      stall_beat = -1; stall_cycles = 0;
      burst(1'b0, 10'h2C8, 2, 1'b0);

      // Reset during beat 2 of a four-beat read.
      accept(1'b0, 10'h03E, 3'd3);
      tick();
      tick();
      check("abort_beat1_valid", 32'(rdata_valid), 32'd1);
      check("abort_beat1_data", 32'(rdata), 32'(ref_mem[10'h03E]));
      tick();                               // access cycle of beat 2
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_ready", 32'(req_ready), 32'd1);
      check("abort_rvalid", 32'(rdata_valid), 32'd0);
      check("abort_rdata", 32'(rdata), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      for (int i = 0; i < 6; i++) begin
         tick();
         check("abort_quiet_rvalid", 32'(rdata_valid), 32'd0);
         check("abort_quiet_done", 32'(done), 32'd0);
      end
      burst(1'b0, 10'h03F, 1, 1'b0);

      // Reset coincident with a write beat: the write must not land.
      bdata[0] = 4'h5; bmask[0] = 4'hF;
      burst(1'b1, 10'h2A7, 0, 1'b0);
      accept(1'b1, 10'h2A7, 3'd0);
      tick();
      wdata_valid = 1'b1; wdata = 4'hA; wmask = 4'hF; rst = 1'b1;
      tick();
      wdata_valid = 1'b0; rst = 1'b0;
      check("rst_write_ready", 32'(req_ready), 32'd1);
      check("rst_write_done", 32'(done), 32'd0);
      burst(1'b0, 10'h2A7, 0, 1'b0);
      check("rst_write_kept", 32'(rdata), 32'h5);

      // Back-to-back: next request accepted in the done cycle.
      fill_beats(4'h9, 4'hF);
      chain_pending = 1'b1; chain_wr = 1'b0; chain_addr = 10'h150; chain_len = 3'd1;
      burst(1'b1, 10'h150, 1, 1'b0);
      burst(1'b0, 10'h150, 1, 1'b1);

      // Randomized bursts against the reference memory.
      for (int it = 0; it < 24; it++) begin
         logic       r_wr;
         logic [9:0] r_addr;
         int         r_len;
         r_wr   = 1'($urandom_range(0, 1));
         r_addr = 10'($urandom_range(0, 1023));
         r_len  = int'($urandom_range(0, 7));
         for (int i = 0; i < 8; i++) begin
            bdata[i] = 4'($urandom_range(0, 15));
            bmask[i] = 4'($urandom_range(0, 15));
         end
         stall_beat   = r_wr ? int'($urandom_range(0, 7)) : -1;
         stall_cycles = int'($urandom_range(0, 3));
         burst(r_wr, r_addr, r_len, 1'b0);
         if (r_wr) begin
            stall_beat = -1;
            burst(1'b0, r_addr, r_len, 1'b0);
         end
      end
      stall_beat = -1;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/sram_burst_core.md
SRAM_BURST_CORE -- requirements
Module: sram_burst_core

Interface
REQ-001 SHALL have parameter ROW_BITS, 6, row address width (2**ROW_BITS rows).
REQ-002 SHALL have parameter COL_BITS, 4, column-word address width (2**COL_BITS words per row).
REQ-003 SHALL have parameter WORD_SIZE, 4, data bits per word; row width = WORD_SIZE*2**COL_BITS.
REQ-004 SHALL have parameter LEN_BITS, 3, burst length field width (max 2**LEN_BITS beats).
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port req_valid  input  1  request offered.
REQ-008 SHALL have port req_ready  output  1  request accepted when both high at a clk edge.
REQ-009 SHALL have port req_write  input  1  1=write burst, 0=read burst.
REQ-010 SHALL have port req_addr  input  ROW_BITS+COL_BITS  start address, [MSBs]=row, [COL_BITS-1:0]=column.
REQ-011 SHALL have port req_len  input  LEN_BITS  beats minus one.
REQ-012 SHALL have port wdata  input  WORD_SIZE  write beat data.
REQ-013 SHALL have port wmask  input  WORD_SIZE  per-bit write enable, 1=write bit.
REQ-014 SHALL have port wdata_valid  input  1  write beat offered.
REQ-015 SHALL have port wdata_ready  output  1  write beat consumed when both high.
REQ-016 SHALL have port rdata  output  WORD_SIZE  read beat data.
REQ-017 SHALL have port rdata_valid  output  1  one-cycle pulse per read beat; no backpressure.
REQ-018 SHALL have port done  output  1  one-cycle pulse at burst completion.

Function
REQ-019 SHALL implement FSM states IDLE, PRE, ACC; req_ready=1 only in IDLE.
REQ-020 SHALL on acceptance latch req_write, row, column, req_len into internal registers and go IDLE->PRE; request inputs then ignored until IDLE.
REQ-021 SHALL hold PRE exactly one cycle (precharge), then ACC.
REQ-022 SHALL in read ACC spend one cycle, capturing the addressed word into rdata; rdata_valid=1 in the following cycle only.
REQ-023 SHALL in write ACC assert wdata_ready and stall until wdata_valid=1; at that edge write array bits where wmask=1, leave others unchanged.
REQ-024 SHALL, leaving ACC with beats remaining, decrement the remaining count, increment column modulo 2**COL_BITS (row unchanged; column 15 wraps to 0), go to PRE.
REQ-025 SHALL, leaving ACC on the final beat, go to IDLE and pulse done in the next cycle (coincident with the last rdata_valid for reads).
REQ-026 SHALL give read latency: acceptance edge T, rdata_valid high in cycle after edge T+2; burst of N beats occupies 2N cycles plus write stalls.
REQ-027 SHALL allow a new request to be accepted in the cycle done is high (back-to-back).
REQ-028 SHALL deassert wdata_ready outside write ACC; wdata_valid ignored there.
REQ-029 SHALL return data written by an earlier completed burst at the same address.

Reset
REQ-030 SHALL on rst: state=IDLE, req_ready=1, wdata_ready=0, rdata=0, rdata_valid=0, done=0, counters=0.
REQ-031 SHALL abort any burst when rst is sampled high; rst wins over a coincident write, so no array write at that edge.
REQ-032 SHALL not clear array contents on rst; simulation model initialises all words to 0 at time zero.

Structure
REQ-033 SHALL place state enum and default parameter constants in shared package sram_pkg.
REQ-034 SHALL instantiate one sub-module sram_array_model (behavioural row storage, masked word write, word read) so the array can be swapped for the analog macro.

Verification
REQ-035 SHALL cover: write addr 0x025 data 0xA mask 0xF len 0, then read 0x025 -> rdata 0xA, rdata_valid 2 cycles after read acceptance edge, done with it.
REQ-036 SHALL cover: write burst addr 0x03E len 3 data 1,2,3,4 -> columns E,F,0,1 of row 3 hold 1,2,3,4; read burst confirms; row 4 untouched.
REQ-037 SHALL cover: word 0xF at 0x100, write 0x0 mask 0x5 -> read returns 0xA.
REQ-038 SHALL cover: write burst with wdata_valid held low 5 cycles -> FSM stays ACC, wdata_ready high, no array change, completes on valid.
REQ-039 SHALL cover: rst asserted during read burst beat 2 of 4 -> next cycle IDLE, no further rdata_valid, no done; subsequent request works.
REQ-040 SHALL cover: new req_valid held high through done -> accepted in done cycle, no idle gap.
